mem_ctrl: RTL
=============

# mem_ctrl

Memory controller inside `cpu`. It arbitrates between the instruction-fetch unit (32-bit reads) and the load/store unit (1/2/4-byte reads and writes) and serializes each request onto the CPU's byte-wide memory bus (`mem_a`/`mem_dout`/`mem_wr`/`mem_din`). It also honours the `rdy_in` pause and `io_buffer_full` back-pressure from the top level.

## Interface
- `IO_SEL`, default 2'b11: value of address bits [17:16] that marks memory-mapped I/O.
- `clk_in`  in  1  system clock; all logic is on the rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  CPU may proceed; low freezes the block.
- `clear_in`  in  1  mispredict flush.
- `if_req`  in  1  instruction fetch request; held until `if_done`.
- `if_addr`  in  32  fetch address (word aligned).
- `if_done`  out  1  one-cycle pulse: `if_data` valid.
- `if_data`  out  32  fetched word, little-endian.
- `ls_req`  in  1  load/store request; held until `ls_done`.
- `ls_wr`  in  1  1 = store, 0 = load.
- `ls_size`  in  2  byte count minus 1: 0, 1 or 3.
- `ls_addr`  in  32  first byte address.
- `ls_wdata`  in  32  store data; the low bytes are used.
- `ls_done`  out  1  one-cycle pulse: access complete.
- `ls_rdata`  out  32  load data, zero-extended.
- `mem_a`  out  32  byte address to the bus.
- `mem_dout`  out  8  write byte.
- `mem_wr`  out  1  1 = write.
- `mem_din`  in  8  read byte, valid one cycle after its address.
- `io_buffer_full`  in  1  UART transmit buffer full.

## Operation
- **States:** IDLE, BUSY_IF, BUSY_LS.
- **Reset values:** state = IDLE; all outputs 0.
- **Arbitration in IDLE:**
  - `ls_req` has priority over `if_req`.
  - The winning request is latched (addr, size, wr, wdata) in the accept cycle.
  - A fetch has N = 4 bytes; a load/store has N = `ls_size`+1 bytes.
- **Byte sequencing:**
  - Byte i uses address base+i (32-bit add, wraps at 2^32).
  - Write byte i = wdata[8i+7:8i].
  - Read byte i lands in data[8i+7:8i].
  - Reads are pipelined: one address per cycle, and each byte is captured one cycle after its address.
- **Idle bus:** `mem_a`=0 and `mem_wr`=0 whenever no byte is issued. Stray reads of I/O space have side effects, so no speculative I/O access is allowed.
- **I/O write back-pressure:** for a store with addr[17:16]==`IO_SEL` while `io_buffer_full`=1, the byte is not issued (`mem_a`=0, `mem_wr`=0). Issue resumes in the first cycle `io_buffer_full`=0.
- **`rdy_in`=0:**
  - No state, counter or capture change.
  - Outputs go to idle values; `mem_wr`=0.
  - An in-flight read byte (address issued, data not yet captured) is discarded and re-issued on the first cycle `rdy_in`=1, because the bus may have been used by the HCI meanwhile.
- **`clear_in`=1 (takes effect with `rdy_in`=1):**
  - BUSY_IF or a load in BUSY_LS: abort. Next state is IDLE, no done pulse, and nothing is issued in that cycle.
  - Store in BUSY_LS: continues to completion.
  - A request arriving in the same cycle as `clear_in` in IDLE is not accepted.
- **Completion:** the done pulse lasts exactly one cycle, with state returning to IDLE in the same edge. A new request can be accepted in the cycle after done.

## Timing
- Request accepted in cycle T (IDLE, `rdy_in`=1, `clear_in`=0).
- **Reads:**
  - Addresses are driven in cycles T+1..T+N.
  - Bytes are captured at the ends of cycles T+2..T+N+1.
  - done and data are registered, valid in cycle T+N+2.
  - 4-byte read: 6 cycles from accept to done.
- **Writes:**
  - `mem_wr`=1 in cycles T+1..T+N.
  - `ls_done` in cycle T+N+1.
  - Single-byte store: done at T+2.
- **Stalls:** every `rdy_in`=0 cycle adds at least 1 cycle. A stall during a read adds its length plus 1 for the re-issue; a stall during a write adds exactly its length. Every `io_buffer_full` cycle on an I/O store adds 1 cycle.
- **Data stability:** `if_data`/`ls_rdata` hold their last value until the next done.

## Test plan
- **Fetch:** RAM[0x100..0x103]=13,00,50,00; `if_req`, `if_addr`=0x100 → `mem_a` 0x100..0x103 in T+1..T+4; `if_done` at T+6 with `if_data`=0x00500013.
- **Arbitration:** `if_req` and `ls_req` (store, size 0, addr 0x200, data 0xAB) rise together → store first (`mem_wr`=1, `mem_a`=0x200, `mem_dout`=0xAB at T+1, `ls_done` at T+2), then the fetch starts at T+3.
- **I/O back-pressure:** store of 0x41 to 0x30000 with `io_buffer_full`=1 for 5 cycles → `mem_wr`=0 for those 5 cycles; a single write of 0x41 follows; `ls_done` one cycle after it.
- **Pause mid-read:** halfword load at 0x10 with `rdy_in`=0 for 3 cycles right after byte 0 is issued → byte 0 re-issued after the pause; `ls_rdata` equals RAM bytes {0x11,0x10}; done at T+4+3+1.
- **Flush:** `clear_in` during fetch byte 2 → no `if_done`, `mem_a`=0 next cycle, state IDLE. `clear_in` during a 4-byte store → all 4 bytes written and `ls_done` asserted.
- **Reset mid-write:** `rst_n_in` low during a store → `mem_wr`=0 immediately; after release, state is IDLE and there is no done.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request and byte-bus signals of the CPU memory controller.
//
// Groups three channels:
//   fetch      : if_req/if_addr in, if_done/if_data out
//   load/store : ls_req/ls_wr/ls_size/ls_addr/ls_wdata in, ls_done/ls_rdata out
//   byte bus   : mem_a/mem_dout/mem_wr out, mem_din in, io_buffer_full in
//
// Handshake: a requester raises *_req with stable operands and holds it until
// the matching *_done pulse (exactly one cycle); data outputs are valid in the
// done cycle and hold until the next done. mem_din carries the byte addressed
// by mem_a one cycle earlier.
//
// modport slave  : the controller side.
// modport master : the requesters plus the memory/IO bus.

interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport slave (
        input  if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        output if_done, if_data, ls_done, ls_rdata, mem_a, mem_dout, mem_wr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        input  if_done, if_data, ls_done, ls_rdata, mem_a, mem_dout, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch (4-byte reads) and load/store
// (1/2/4-byte reads and writes) onto the byte-wide CPU memory bus.
//
// Ports:
//   clk_in    : clock, rising edge
//   rst_n_in  : asynchronous active-low reset
//   rdy_in    : low freezes the controller and idles the bus
//   clear_in  : mispredict flush (aborts fetches and loads, not stores)
//   bus       : mem_ctrl_if.slave (fetch, load/store and byte-bus signals)
//   state_o   : current FSM state (0 IDLE, 1 BUSY_IF, 2 BUSY_LS)
//
// Bus outputs are combinational from the registered sequencing state so that
// rdy_in, clear_in and io_buffer_full can suppress a byte in the same cycle.
// Done pulses and returned data are registered.

module mem_ctrl #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rdy_in,
    input  logic       clear_in,
    mem_ctrl_if.slave  bus,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;       // first byte address
    logic [1:0]  last_q, last_d;       // index of the final byte (N-1)
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;         // writes: bytes issued; reads: bytes captured
    logic        pend_q, pend_d;       // a read byte was addressed last cycle
    logic [31:0] data_q, data_d;       // read assembly register
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        issue;
    logic [2:0]  idx;
    logic [2:0]  rd_cnt;
    logic [31:0] data_cap;
    logic        io_block;

    // Stores into I/O space wait while the UART buffer is full.
    assign io_block = wr_q && (base_q[17:16] == IO_SEL) && bus.io_buffer_full;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        last_d     = last_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        data_d     = data_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        issue      = 1'b0;
        idx        = cnt_q;
        // Next read byte to address: one past the in-flight byte, if any.
        rd_cnt     = cnt_q + {2'b00, pend_q};
        data_cap   = data_q;
        if (pend_q) begin
            data_cap[{cnt_q[1:0], 3'b000} +: 8] = bus.mem_din;
        end

        case (state_q)
            IDLE: begin
                // The done cycle is skipped so a still-held request is not
                // accepted a second time.
                if (rdy_in && !clear_in && !if_done_q && !ls_done_q) begin
                    if (bus.ls_req) begin
                        state_d = BUSY_LS;
                        base_d  = bus.ls_addr;
                        last_d  = bus.ls_size;
                        wr_d    = bus.ls_wr;
                        wdata_d = bus.ls_wdata;
                        cnt_d   = 3'd0;
                        pend_d  = 1'b0;
                        data_d  = 32'd0;
                    end else if (bus.if_req) begin
                        state_d = BUSY_IF;
                        base_d  = bus.if_addr;
                        last_d  = 2'd3;
                        wr_d    = 1'b0;
                        wdata_d = 32'd0;
                        cnt_d   = 3'd0;
                        pend_d  = 1'b0;
                        data_d  = 32'd0;
                    end
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (!rdy_in) begin
                    // The bus may be reused while paused: drop the in-flight
                    // read so it is addressed again on resume.
                    pend_d = 1'b0;
                end else if (clear_in && !wr_q) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end else if (wr_q) begin
                    if (!io_block) begin
                        issue = 1'b1;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q[1:0] == last_q) begin
                            ls_done_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end else begin
                    data_d = data_cap;
                    cnt_d  = rd_cnt;
                    idx    = rd_cnt;
                    if (rd_cnt <= {1'b0, last_q}) begin
                        issue  = 1'b1;
                        pend_d = 1'b1;
                    end else begin
                        pend_d = 1'b0;
                    end
                    if (pend_q && (cnt_q[1:0] == last_q)) begin
                        state_d = IDLE;
                        if (state_q == BUSY_IF) begin
                            if_done_d = 1'b1;
                            if_data_d = data_cap;
                        end else begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = data_cap;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            base_q     <= 32'd0;
            last_q     <= 2'd0;
            wr_q       <= 1'b0;
            wdata_q    <= 32'd0;
            cnt_q      <= 3'd0;
            pend_q     <= 1'b0;
            data_q     <= 32'd0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.mem_a    = issue ? (base_q + {29'd0, idx}) : 32'd0;
    assign bus.mem_wr   = issue & wr_q;
    assign bus.mem_dout = (issue & wr_q) ? wdata_q[{idx[1:0], 3'b000} +: 8] : 8'd0;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;
    assign state_o      = state_q;

endmodule
